// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: hardware loop-nest sequencer for pe_array.
// Computes OA[M][N] = IA[M][K] x W[K][N] one MAC_NUM-row tile at a time.
// Each tile reads K activation/weight word pairs, drains the MAC
// pipeline and writes one packed result word to the output SRAM.
module pe_array_ctrl #(
  parameter int MAC_NUM = 4,
  parameter int BW_ACT  = 8,
  parameter int BW_WET  = 8,
  parameter int ADDR_W  = 16,
  parameter int CFG_W   = 16,
  parameter int RES_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CFG_W-1:0]          cfg_m_tiles,
  input  logic [CFG_W-1:0]          cfg_k,
  input  logic [CFG_W-1:0]          cfg_n,
  input  logic [7:0]                cfg_shift,
  output logic                      busy,
  output logic                      done,
  output logic                      act_rd_en,
  output logic [ADDR_W-1:0]         act_rd_addr,
  input  logic [MAC_NUM*BW_ACT-1:0] act_rd_data,
  output logic                      wet_rd_en,
  output logic [ADDR_W-1:0]         wet_rd_addr,
  input  logic [BW_WET-1:0]         wet_rd_data,
  output logic                      pe_mac_enable,
  output logic                      pe_clear_acc,
  output logic [MAC_NUM*BW_ACT-1:0] pe_act_in,
  output logic [BW_WET-1:0]         pe_wet_in,
  output logic [7:0]                pe_res_shift_num,
  input  logic [MAC_NUM*BW_ACT-1:0] pe_result_in,
  output logic                      out_wr_en,
  output logic [ADDR_W-1:0]         out_wr_addr,
  output logic [MAC_NUM*BW_ACT-1:0] out_wr_data
);

  localparam int CNT_W = (RES_LAT < 2) ? 1 : $clog2(RES_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE,
    FIN
  } state_e;

  state_e             state_q, state_d;
  logic [CFG_W-1:0]   cfgMTiles_q, cfgMTiles_d;
  logic [CFG_W-1:0]   cfgK_q, cfgK_d;
  logic [CFG_W-1:0]   cfgN_q, cfgN_d;
  logic [7:0]         shift_q, shift_d;
  logic               zeroCfg_q, zeroCfg_d;
  logic [CFG_W-1:0]   mIdx_q, mIdx_d;
  logic [CFG_W-1:0]   jIdx_q, jIdx_d;
  logic [CFG_W-1:0]   iIdx_q, iIdx_d;
  logic [CNT_W-1:0]   latCnt_q, latCnt_d;
  logic [ADDR_W-1:0]  actBase_q, actBase_d;
  logic [ADDR_W-1:0]  wetBase_q, wetBase_d;
  logic [ADDR_W-1:0]  outAddr_q, outAddr_d;
  logic               dataCyc_q, dataCyc_d;
  logic               issuing;
  logic [ADDR_W-1:0]  kAddr;

  assign kAddr = ADDR_W'(cfgK_q);

  // Next-state logic. Address bases advance incrementally (j*K, m*K and
  // m*cfg_m_tiles+j) so no multipliers are needed. A zero-sized job still
  // passes through ISSUE for one idle cycle so busy is visible before done.
  always_comb begin
    state_d     = state_q;
    cfgMTiles_d = cfgMTiles_q;
    cfgK_d      = cfgK_q;
    cfgN_d      = cfgN_q;
    shift_d     = shift_q;
    zeroCfg_d   = zeroCfg_q;
    mIdx_d      = mIdx_q;
    jIdx_d      = jIdx_q;
    iIdx_d      = iIdx_q;
    latCnt_d    = latCnt_q;
    actBase_d   = actBase_q;
    wetBase_d   = wetBase_q;
    outAddr_d   = outAddr_q;
    dataCyc_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cfgMTiles_d = cfg_m_tiles;
          cfgK_d      = cfg_k;
          cfgN_d      = cfg_n;
          shift_d     = cfg_shift;
          zeroCfg_d   = (cfg_m_tiles == '0) || (cfg_k == '0) || (cfg_n == '0);
          mIdx_d      = '0;
          jIdx_d      = '0;
          iIdx_d      = '0;
          actBase_d   = '0;
          wetBase_d   = '0;
          outAddr_d   = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (zeroCfg_q) begin
          state_d = FIN;
        end else begin
          dataCyc_d = 1'b1;
          if (iIdx_q == cfgK_q - CFG_W'(1)) begin
            iIdx_d   = '0;
            latCnt_d = '0;
            state_d  = DRAIN;
          end else begin
            iIdx_d = iIdx_q + CFG_W'(1);
          end
        end
      end
      DRAIN: begin
        if (latCnt_q == CNT_W'(RES_LAT)) begin
          state_d = WRITE;
        end else begin
          latCnt_d = latCnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        outAddr_d = outAddr_q + ADDR_W'(1);
        if (jIdx_q == cfgMTiles_q - CFG_W'(1)) begin
          jIdx_d    = '0;
          actBase_d = '0;
          wetBase_d = wetBase_q + kAddr;
          if (mIdx_q == cfgN_q - CFG_W'(1)) begin
            state_d = FIN;
          end else begin
            mIdx_d  = mIdx_q + CFG_W'(1);
            state_d = ISSUE;
          end
        end else begin
          jIdx_d    = jIdx_q + CFG_W'(1);
          actBase_d = actBase_q + kAddr;
          state_d   = ISSUE;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous reset; a reset mid-job
  // simply abandons the job.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cfgMTiles_q <= '0;
      cfgK_q      <= '0;
      cfgN_q      <= '0;
      shift_q     <= '0;
      zeroCfg_q   <= 1'b0;
      mIdx_q      <= '0;
      jIdx_q      <= '0;
      iIdx_q      <= '0;
      latCnt_q    <= '0;
      actBase_q   <= '0;
      wetBase_q   <= '0;
      outAddr_q   <= '0;
      dataCyc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfgMTiles_q <= cfgMTiles_d;
      cfgK_q      <= cfgK_d;
      cfgN_q      <= cfgN_d;
      shift_q     <= shift_d;
      zeroCfg_q   <= zeroCfg_d;
      mIdx_q      <= mIdx_d;
      jIdx_q      <= jIdx_d;
      iIdx_q      <= iIdx_d;
      latCnt_q    <= latCnt_d;
      actBase_q   <= actBase_d;
      wetBase_q   <= wetBase_d;
      outAddr_q   <= outAddr_d;
      dataCyc_q   <= dataCyc_d;
    end
  end

  // Output decode: reads in ISSUE, SRAM data passed through to the PEs one
  // cycle later (data cycle), accumulators held in clear at all other times.
  always_comb begin
    issuing          = (state_q == ISSUE) && !zeroCfg_q;
    act_rd_en        = issuing;
    wet_rd_en        = issuing;
    act_rd_addr      = issuing ? (actBase_q + ADDR_W'(iIdx_q)) : '0;
    wet_rd_addr      = issuing ? (wetBase_q + ADDR_W'(iIdx_q)) : '0;
    busy             = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == WRITE);
    done             = (state_q == FIN);
    pe_mac_enable    = busy;
    pe_clear_acc     = !dataCyc_q;
    pe_act_in        = dataCyc_q ? act_rd_data : '0;
    pe_wet_in        = dataCyc_q ? wet_rd_data : '0;
    pe_res_shift_num = shift_q;
    out_wr_en        = (state_q == WRITE);
    out_wr_addr      = (state_q == WRITE) ? outAddr_q : '0;
    out_wr_data      = (state_q == WRITE) ? pe_result_in : '0;
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Testbench for pe_array_ctrl: SRAM and pe_array behavioural models, an
// expected-read/expected-write scoreboard and directed job scenarios.
module tb_pe_array_ctrl;

  localparam int MAC_NUM = 4;
  localparam int BW_ACT  = 8;
  localparam int BW_WET  = 8;
  localparam int ADDR_W  = 16;
  localparam int CFG_W   = 16;
  localparam int RES_LAT = 2;

  logic                      clk;
  logic                      reset;
  logic                      start;
  logic [CFG_W-1:0]          cfg_m_tiles, cfg_k, cfg_n;
  logic [7:0]                cfg_shift;
  logic                      busy, done;
  logic                      act_rd_en, wet_rd_en;
  logic [ADDR_W-1:0]         act_rd_addr, wet_rd_addr;
  logic [MAC_NUM*BW_ACT-1:0] act_rd_data;
  logic [BW_WET-1:0]         wet_rd_data;
  logic                      pe_mac_enable, pe_clear_acc;
  logic [MAC_NUM*BW_ACT-1:0] pe_act_in;
  logic [BW_WET-1:0]         pe_wet_in;
  logic [7:0]                pe_res_shift_num;
  logic [MAC_NUM*BW_ACT-1:0] pe_result_in;
  logic                      out_wr_en;
  logic [ADDR_W-1:0]         out_wr_addr;
  logic [MAC_NUM*BW_ACT-1:0] out_wr_data;

  pe_array_ctrl #(
    .MAC_NUM(MAC_NUM), .BW_ACT(BW_ACT), .BW_WET(BW_WET),
    .ADDR_W(ADDR_W), .CFG_W(CFG_W), .RES_LAT(RES_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_m_tiles(cfg_m_tiles), .cfg_k(cfg_k), .cfg_n(cfg_n), .cfg_shift(cfg_shift),
    .busy(busy), .done(done),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .wet_rd_en(wet_rd_en), .wet_rd_addr(wet_rd_addr), .wet_rd_data(wet_rd_data),
    .pe_mac_enable(pe_mac_enable), .pe_clear_acc(pe_clear_acc),
    .pe_act_in(pe_act_in), .pe_wet_in(pe_wet_in),
    .pe_res_shift_num(pe_res_shift_num), .pe_result_in(pe_result_in),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [31:0] actMem [256];
  logic [7:0]  wetMem [256];

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wrExp_t;

  typedef struct packed {
    logic [15:0] act;
    logic [15:0] wet;
  } rdExp_t;

  wrExp_t wrQ [$];
  rdExp_t rdQ [$];
  wrExp_t wrPop;
  rdExp_t rdPop;

  logic signed [31:0] acc [MAC_NUM];
  logic [31:0]        resPipe [RES_LAT];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic int mulLane(input logic [7:0] a, input logic [7:0] w);
    int ai;
    int wi;
    ai = $signed(a);
    wi = $signed(w);
    return ai * wi;
  endfunction

  // Registered-read SRAM models
  always @(posedge clk) begin
    if (reset) begin
      act_rd_data <= '0;
      wet_rd_data <= '0;
    end else begin
      if (act_rd_en) act_rd_data <= actMem[act_rd_addr[7:0]];
      if (wet_rd_en) wet_rd_data <= wetMem[wet_rd_addr[7:0]];
    end
  end

  // Behavioural pe_array: signed MAC per lane, shifted result delayed RES_LAT cycles
  always @(posedge clk) begin
    for (int l = 0; l < MAC_NUM; l++) begin
      if (pe_clear_acc) acc[l] <= 0;
      else if (pe_mac_enable) acc[l] <= acc[l] + mulLane(pe_act_in[l*8 +: 8], pe_wet_in);
      resPipe[0][l*8 +: 8] <= 8'(acc[l] >>> pe_res_shift_num);
    end
    for (int s = 1; s < RES_LAT; s++) resPipe[s] <= resPipe[s-1];
  end
  assign pe_result_in = resPipe[RES_LAT-1];

  // Monitor: pops the scoreboard whenever the DUT reads or writes
  always @(negedge clk) begin
    if (out_wr_en) begin
      if (wrQ.size() == 0) begin
        checkOutput("unexpected_write", {48'd0, out_wr_addr}, 64'hFFFF_FFFF);
      end else begin
        wrPop = wrQ.pop_front();
        checkOutput("wr_addr", out_wr_addr, wrPop.addr);
        checkOutput("wr_data", out_wr_data, wrPop.data);
      end
    end
    if (act_rd_en || wet_rd_en) begin
      checkOutput("rd_en_pair", {63'd0, act_rd_en}, {63'd0, wet_rd_en});
      if (rdQ.size() == 0) begin
        checkOutput("unexpected_read", {48'd0, act_rd_addr}, 64'hFFFF_FFFF);
      end else begin
        rdPop = rdQ.pop_front();
        checkOutput("act_rd_addr", act_rd_addr, rdPop.act);
        checkOutput("wet_rd_addr", wet_rd_addr, rdPop.wet);
      end
    end
  end

  task automatic pushReads(input int mt, input int k, input int n);
    rdExp_t r;
    for (int m = 0; m < n; m++)
      for (int j = 0; j < mt; j++)
        for (int i = 0; i < k; i++) begin
          r.act = 16'(j*k + i);
          r.wet = 16'(m*k + i);
          rdQ.push_back(r);
        end
  endtask

  // Reference matmul over the SRAM contents
  task automatic pushExpected(input int mt, input int k, input int n, input int sh);
    wrExp_t w;
    int sum;
    pushReads(mt, k, n);
    for (int m = 0; m < n; m++)
      for (int j = 0; j < mt; j++) begin
        w.addr = 16'(m*mt + j);
        for (int l = 0; l < MAC_NUM; l++) begin
          sum = 0;
          for (int i = 0; i < k; i++) sum += mulLane(actMem[j*k+i][l*8 +: 8], wetMem[m*k+i]);
          w.data[l*8 +: 8] = 8'(sum >>> sh);
        end
        wrQ.push_back(w);
      end
  endtask

  task automatic applyStimulus(input int mt, input int k, input int n, input int sh, input bit midStart,
                               output int doneCyc, output int clearLow, output int rdCnt,
                               output int wrCnt, output int busyCnt);
    int limit;
    limit    = mt*n*(k + RES_LAT + 2) + 20;
    doneCyc  = -1;
    clearLow = 0;
    rdCnt    = 0;
    wrCnt    = 0;
    busyCnt  = 0;
    @(negedge clk);
    cfg_m_tiles = 16'(mt);
    cfg_k       = 16'(k);
    cfg_n       = 16'(n);
    cfg_shift   = 8'(sh);
    start       = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start       = 1'b0;
        cfg_m_tiles = 16'd7;
        cfg_k       = 16'd9;
        cfg_n       = 16'd5;
        cfg_shift   = 8'd3;
      end
      if (midStart && c == 3) begin
        start       = 1'b1;
        cfg_m_tiles = 16'd1;
        cfg_k       = 16'd1;
        cfg_n       = 16'd1;
      end
      if (midStart && c == 4) start = 1'b0;
      if (!pe_clear_acc) clearLow++;
      if (act_rd_en) rdCnt++;
      if (out_wr_en) wrCnt++;
      if (busy) busyCnt++;
      if (done) begin
        doneCyc = c;
        break;
      end
    end
    start = 1'b0;
    if (doneCyc < 0) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic checkDrained(input string tag);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_wrq_empty"}, 64'(wrQ.size()), 64'd0);
    checkOutput({tag, "_rdq_empty"}, 64'(rdQ.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc, cl, rc, wc, bc;
    wrExp_t w;
    reset       = 1'b1;
    start       = 1'b0;
    cfg_m_tiles = '0;
    cfg_k       = '0;
    cfg_n       = '0;
    cfg_shift   = '0;
    for (int a = 0; a < 256; a++) begin
      actMem[a] = '0;
      wetMem[a] = '0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_rd_en", {62'd0, act_rd_en, wet_rd_en}, 64'd0);
    checkOutput("rst_wr_en", {63'd0, out_wr_en}, 64'd0);
    checkOutput("rst_mac_en", {63'd0, pe_mac_enable}, 64'd0);
    checkOutput("rst_clear", {63'd0, pe_clear_acc}, 64'd1);
    checkOutput("rst_addrs", {act_rd_addr, wet_rd_addr, out_wr_addr}, 64'd0);
    checkOutput("rst_pe_data", {pe_act_in, pe_wet_in, pe_res_shift_num}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single tile: lane sums 10, 8, -4, 5 with unit weights
    for (int i = 0; i < 4; i++) begin
      actMem[i] = {(i == 0) ? 8'd5 : 8'd0, 8'hFF, 8'h02, 8'(i + 1)};
      wetMem[i] = 8'd1;
    end
    pushReads(1, 4, 1);
    w.addr = 16'd0;
    w.data = 32'h05FC_080A;
    wrQ.push_back(w);
    applyStimulus(1, 4, 1, 0, 1'b0, dc, cl, rc, wc, bc);
    checkOutput("t1_done_cycles", 64'(dc), 64'd9);
    checkOutput("t1_clear_low", 64'(cl), 64'd4);
    checkOutput("t1_writes", 64'(wc), 64'd1);
    checkOutput("t1_reads", 64'(rc), 64'd4);
    checkDrained("t1");

    // Ordering: 2 row tiles x 2 columns, K=3
    for (int a = 0; a < 6; a++) begin
      actMem[a] = {8'(a - 3), 8'(2*a), 8'(1 - a), 8'(a + 1)};
      wetMem[a] = 8'(a - 2);
    end
    pushExpected(2, 3, 2, 0);
    applyStimulus(2, 3, 2, 0, 1'b0, dc, cl, rc, wc, bc);
    checkOutput("t2_done_cycles", 64'(dc), 64'd29);
    checkOutput("t2_writes", 64'(wc), 64'd4);
    checkOutput("t2_clear_low", 64'(cl), 64'd12);
    checkDrained("t2");

    // Zero K: one busy cycle, no activity
    applyStimulus(1, 0, 1, 0, 1'b0, dc, cl, rc, wc, bc);
    checkOutput("t3_done_cycles", 64'(dc), 64'd2);
    checkOutput("t3_busy_cycles", 64'(bc), 64'd1);
    checkOutput("t3_reads", 64'(rc), 64'd0);
    checkOutput("t3_writes", 64'(wc), 64'd0);
    checkOutput("t3_clear_low", 64'(cl), 64'd0);

    // Zero m_tiles behaves the same way
    applyStimulus(0, 3, 2, 0, 1'b0, dc, cl, rc, wc, bc);
    checkOutput("t3b_done_cycles", 64'(dc), 64'd2);
    checkOutput("t3b_activity", 64'(rc + wc + cl), 64'd0);

    // start re-asserted mid-job with different cfg is ignored
    for (int a = 0; a < 8; a++) begin
      actMem[a] = {8'(7*a + 1), 8'(-a), 8'(a*a), 8'(20 - 5*a)};
      wetMem[a] = 8'(3 - a);
    end
    pushExpected(1, 4, 2, 1);
    applyStimulus(1, 4, 2, 1, 1'b1, dc, cl, rc, wc, bc);
    checkOutput("t4_done_cycles", 64'(dc), 64'd17);
    checkOutput("t4_writes", 64'(wc), 64'd2);
    checkDrained("t4");

    // Reset in the third ISSUE cycle of tile 1 (cycle 11); tile 0 write only
    pushReads(1, 4, 1);
    for (int i = 0; i < 3; i++) begin
      rdExp_t r;
      r.act = 16'(i);
      r.wet = 16'(4 + i);
      rdQ.push_back(r);
    end
    begin
      int sum;
      w.addr = 16'd0;
      for (int l = 0; l < MAC_NUM; l++) begin
        sum = 0;
        for (int i = 0; i < 4; i++) sum += mulLane(actMem[i][l*8 +: 8], wetMem[i]);
        w.data[l*8 +: 8] = 8'(sum);
      end
      wrQ.push_back(w);
    end
    @(negedge clk);
    cfg_m_tiles = 16'd1;
    cfg_k       = 16'd4;
    cfg_n       = 16'd2;
    cfg_shift   = 8'd0;
    start       = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 11) begin
        checkOutput("t5_pre_rd_en", {63'd0, act_rd_en}, 64'd1);
        reset = 1'b1;
      end
      if (c == 12) begin
        checkOutput("t5_busy", {63'd0, busy}, 64'd0);
        checkOutput("t5_clear", {63'd0, pe_clear_acc}, 64'd1);
        checkOutput("t5_wr_en", {63'd0, out_wr_en}, 64'd0);
        checkOutput("t5_rd_en", {63'd0, act_rd_en}, 64'd0);
        reset = 1'b0;
      end
    end
    repeat (10) @(negedge clk);
    checkDrained("t5");

    // Fresh job after reset: random signed data, 2 row tiles, K=5, N=3, shift 2
    for (int a = 0; a < 16; a++) begin
      actMem[a] = $urandom;
      wetMem[a] = 8'($urandom);
    end
    pushExpected(2, 5, 3, 2);
    applyStimulus(2, 5, 3, 2, 1'b0, dc, cl, rc, wc, bc);
    checkOutput("t6_done_cycles", 64'(dc), 64'd55);
    checkOutput("t6_writes", 64'(wc), 64'd6);
    checkOutput("t6_reads", 64'(rc), 64'd30);
    checkDrained("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
